// File: rtl/ad9958_pkg.sv
// Shared types and constants for the AD9958 serial-port arbiter.
package ad9958_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    COMPLETE  = 2'd3
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam int unsigned MAX_PACKS_DEF = 8;
  localparam int unsigned PACKS_W       = 5;
  localparam int unsigned DATA_W        = 64;
  localparam int unsigned TIMER_W       = 16;

endpackage

// File: rtl/ad9958_spi_arbiter.sv
// Round-robin arbiter sharing one AD9958 SPI engine between the core
// update sequencer (requester 0, lockable) and the host access path (requester 1).
module ad9958_spi_arbiter
  import ad9958_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_PACKS      = MAX_PACKS_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req0_valid,
  input  logic [PACKS_W-1:0] req0_packs,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic               req0_lock,
  input  logic               req1_valid,
  input  logic [PACKS_W-1:0] req1_packs,
  input  logic [DATA_W-1:0]  req1_data,
  output logic               req0_ready,
  output logic               req1_ready,
  output logic               req0_done,
  output logic               req1_done,
  output logic               spi_trigger,
  output logic [PACKS_W-1:0] spi_packs,
  output logic [DATA_W-1:0]  spi_data,
  input  logic               spi_busy,
  output logic               owner,
  output logic               idle,
  output logic               err_timeout,
  output logic               err_len
);

  localparam int unsigned TINC_W = TIMER_W + 1;

  state_t             state;
  logic               last_grant;
  logic               lock_flag;
  logic               timeout_hit;
  logic [TIMER_W-1:0] timer;

  logic               elig0;
  logic               elig1;
  logic               grant_valid;
  logic               grant_id;
  logic [PACKS_W-1:0] sel_packs;
  logic [DATA_W-1:0]  sel_data;
  logic [TINC_W-1:0]  timer_inc;

  // Round-robin pick; the lock makes requester 1 ineligible.
  always_comb begin
    elig0       = req0_valid;
    elig1       = req1_valid && !lock_flag;
    grant_valid = !spi_busy && (elig0 || elig1);
    grant_id    = (elig0 && elig1) ? ~last_grant : elig1;
    sel_packs   = (grant_id == REQ_HOST) ? req1_packs : req0_packs;
    sel_data    = (grant_id == REQ_HOST) ? req1_data  : req0_data;
    timer_inc   = {1'b0, timer} + TINC_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      idle        <= 1'b1;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      spi_trigger <= 1'b0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
      spi_packs   <= '0;
      spi_data    <= '0;
      owner       <= REQ_CORE;
      last_grant  <= REQ_HOST;
      lock_flag   <= 1'b0;
      timeout_hit <= 1'b0;
      timer       <= '0;
    end else begin
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      spi_trigger <= 1'b0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;

      case (state)
        IDLE: begin
          if (lock_flag && !req0_lock) lock_flag <= 1'b0;
          if (grant_valid) begin
            owner       <= grant_id;
            last_grant  <= grant_id;
            spi_packs   <= sel_packs;
            spi_data    <= sel_data;
            req0_ready  <= (grant_id == REQ_CORE);
            req1_ready  <= (grant_id == REQ_HOST);
            idle        <= 1'b0;
            timer       <= '0;
            timeout_hit <= 1'b0;
            // Null and oversize transactions skip the engine entirely.
            if (sel_packs == '0) begin
              state <= COMPLETE;
            end else if (sel_packs > PACKS_W'(MAX_PACKS)) begin
              err_len <= 1'b1;
              state   <= COMPLETE;
            end else begin
              spi_trigger <= 1'b1;
              state       <= WAIT_BUSY;
            end
          end
        end

        WAIT_BUSY: begin
          if (spi_busy) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else begin
            timer <= timer_inc[TIMER_W-1:0];
            if (timer_inc == TINC_W'(TIMEOUT_CYCLES)) begin
              timeout_hit <= 1'b1;
              state       <= COMPLETE;
            end
          end
        end

        WAIT_DONE: begin
          if (!spi_busy) state <= COMPLETE;
        end

        COMPLETE: begin
          req0_done   <= (owner == REQ_CORE);
          req1_done   <= (owner == REQ_HOST);
          err_timeout <= timeout_hit;
          timeout_hit <= 1'b0;
          lock_flag   <= (owner == REQ_CORE) && req0_lock;
          idle        <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          idle  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ad9958_spi_arbiter.md
# ad9958_spi_arbiter

- Shares the single AD9958 serial-port engine between two requesters: requester 0 is the core update sequencer, requester 1 is the host register-access path.
- Sits between those requesters and the SPI engine's `trigger` / `packs_to_send` / `data_input` / `busy` interface.
- Arbitrates round-robin, lets requester 0 lock the port across a multi-transaction update sequence, and enforces length and timeout rules.
- Reports completion per requester.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait for spi_busy to rise after a trigger before aborting (1..65535).
- MAX_PACKS, 8, largest legal transaction length in packs.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req0_valid / req1_valid  in  1  transaction request; held until the matching ready.
- req0_packs / req1_packs  in  5  transaction length in packs.
- req0_data / req1_data  in  64  payload, MSB-first.
- req0_lock  in  1  requester 0 keeps ownership after its transaction completes.
- req0_ready / req1_ready  out  1  one-cycle accept pulse.
- req0_done / req1_done  out  1  one-cycle completion pulse.
- spi_trigger  out  1  one-cycle start pulse to the SPI engine.
- spi_packs  out  5  latched length.
- spi_data  out  64  latched payload.
- spi_busy  in  1  SPI engine busy.
- owner  out  1  requester currently granted; valid when `idle`=0.
- idle  out  1  arbiter in IDLE.
- err_timeout  out  1  one-cycle pulse on timeout abort.
- err_len  out  1  one-cycle pulse on illegal-length rejection.

## Operation
- Reset values:
  - State IDLE, `idle`=1.
  - All pulses 0.
  - `spi_packs`=0, `spi_data`=0, `owner`=0.
  - `last_grant`=1, so requester 0 wins the first contention.
  - Lock flag cleared, timeout counter 0.
- IDLE:
  - Grants only when `spi_busy`=0; if the engine is still busy from before a reset, IDLE waits.
  - One requester valid: grant it.
  - Both valid: grant `~last_grant`.
  - Lock flag set: only requester 0 is eligible; requester 1 waits.
- Accept:
  - Latch packs and data, set owner/`last_grant`, pulse ready.
  - Then branch on length:
    - packs in 1..MAX_PACKS: pulse `spi_trigger`, go to WAIT_BUSY.
    - packs = 0: null transaction; no trigger; go to COMPLETE.
    - packs > MAX_PACKS: pulse `err_len`; no trigger; go to COMPLETE.
- WAIT_BUSY:
  - Counter increments each cycle.
  - `spi_busy`=1: clear counter, go to WAIT_DONE.
  - Counter reaches TIMEOUT_CYCLES: pulse `err_timeout`, go to COMPLETE.
- WAIT_DONE: stay until `spi_busy`=0, then go to COMPLETE. No timeout here.
- COMPLETE:
  - Pulse owner's done.
  - Lock flag <= (owner==0 && `req0_lock`), sampled this cycle.
  - Return to IDLE.
- Lock release: a lock flag set with `req0_lock` already low is cleared in IDLE on the next cycle, and requester 1 is eligible again.
- `spi_packs`/`spi_data` hold their latched values until the next accept; they never change while the SPI engine is busy.
- Requester 1 is never starved by round-robin; it is starved only while requester 0 holds the lock.

## Timing
- Valid sampled high at edge k in IDLE, with `spi_busy`=0: ready, `spi_trigger`, and new `spi_packs`/`spi_data` are all visible after edge k. Zero added latency.
- Done asserts one cycle after `spi_busy` is sampled low in WAIT_DONE.
- Earliest next accept: the cycle after done (one IDLE cycle minimum). Back-to-back period is therefore busy duration + 3 cycles.
- Null/illegal transaction: ready at k, done at k+1.
- Timeout: `err_timeout` and done assert together, exactly TIMEOUT_CYCLES+1 cycles after trigger.
- Valid deasserted before ready: request withdrawn, nothing latched. Requesters must not do this, but the arbiter tolerates it.
- `reset_n` low mid-transaction: the next edge forces reset values. Any in-flight done is lost; the requester re-issues.

## Structure
- Shared package `ad9958_pkg` holds:
  - State enum: IDLE, WAIT_BUSY, WAIT_DONE, COMPLETE.
  - Requester IDs REQ_CORE=0 and REQ_HOST=1.
  - MAX_PACKS default.
  - Pack-count width (5).
- Single module; no sub-module. The round-robin pick and timeout counter are small enough to stay inline.

## Test plan
- Single request: req0 valid, packs=4, data=64'hA5A5_0000_0000_1234 → ready+trigger the same cycle with matching spi outputs. Busy high 10 cycles → req0_done 1 cycle after busy falls.
- Contention: both valid continuously from reset → grants 0,1,0,1; each done arrives before the next ready.
- Lock: req0_lock=1 during three req0 transactions with req1 pending → req1 not granted until the COMPLETE after req0_lock drops, then granted next.
- Length boundaries:
  - packs=0 → ready, done next cycle, no trigger.
  - packs=9 → ready, err_len, done next cycle, no trigger.
  - packs=8 → normal transaction.
- Timeout: TIMEOUT_CYCLES=16, busy never rises → err_timeout and done at trigger+17; arbiter returns to IDLE and accepts the next request.
- Reset mid-op: assert reset_n=0 in WAIT_DONE while busy=1 → all outputs reset. Hold busy=1 after release → no grant until busy=0.
